wr_port_arbiter: RTL and testbench

Packet-granular write arbiter sharing the single SRAM write datapath (the scatter-gather write stage) among `num_of_ports` ingress ports. It picks one requesting port by priority with round-robin tie-break, drives `transfering` to the write stage for the whole packet, and releases the grant on that port's end-of-packet or on a beat-count timeout. It sits between the per-port ingress buffers and the write stage, and steers their data, address and destination muxes via `grant_idx`.

---
 rtl/wr_port_arbiter_if.sv | 28 ++
 rtl/wr_port_arbiter.sv | 173 +++++++++++++++++
 tb/tb_wr_port_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/wr_port_arbiter_if.sv
// rtl/wr_port_arbiter_if.sv - request/grant bundle between ingress ports, arbiter and write stage
interface wr_port_arbiter_if #(
   parameter int num_of_ports      = 16,
   parameter int sg_priority_width = 3,
   parameter int idx_width         = 4,
   parameter int cnt_width         = 7
);
   logic [num_of_ports-1:0]                   req;
   logic [num_of_ports*sg_priority_width-1:0] prio_flat;
   logic [num_of_ports-1:0]                   eop;
   logic                                      busy;
   logic [num_of_ports-1:0]                   grant;
   logic [idx_width-1:0]                      grant_idx;
   logic                                      transfering;
   logic [cnt_width-1:0]                      beat_cnt;
   logic                                      pkt_done;
   logic                                      timeout_err;

   modport slave (
      input  req, prio_flat, eop, busy,
      output grant, grant_idx, transfering, beat_cnt, pkt_done, timeout_err
   );

   modport master (
      output req, prio_flat, eop, busy,
      input  grant, grant_idx, transfering, beat_cnt, pkt_done, timeout_err
   );
endinterface

// File: rtl/wr_port_arbiter.sv
// rtl/wr_port_arbiter.sv - packet-granular priority/round-robin arbiter for the SRAM write datapath
// Optional starvation guard: define WRARB_AGING_EN to add per-port age counters.
module wr_port_arbiter #(
   parameter int num_of_ports      = 16,
   parameter int sg_priority_width = 3,
   parameter int idx_width         = 4,
   parameter int max_beats         = 64,
   parameter int cnt_width         = 7
`ifdef WRARB_AGING_EN
   ,parameter int age_width        = 4
`endif
) (
   input  logic               i_clk,
   input  logic               i_rst,
   wr_port_arbiter_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_XFER, S_GAP} state_t;

   localparam int key_w = sg_priority_width + 1;

   state_t                  r_state;
   logic [num_of_ports-1:0] r_grant;
   logic [idx_width-1:0]    r_grant_idx;
   logic                    r_transfering;
   logic [cnt_width-1:0]    r_beat_cnt;
   logic                    r_pkt_done;
   logic                    r_timeout_err;
   logic [idx_width-1:0]    r_rr_ptr;

   state_t                  w_state_nxt;
   logic [num_of_ports-1:0] w_grant_nxt;
   logic [idx_width-1:0]    w_grant_idx_nxt;
   logic                    w_transfering_nxt;
   logic [cnt_width-1:0]    w_beat_cnt_nxt;
   logic                    w_pkt_done_nxt;
   logic                    w_timeout_err_nxt;
   logic [idx_width-1:0]    w_rr_ptr_nxt;

   logic [num_of_ports-1:0] w_urgent;
   logic [key_w-1:0]        w_key [num_of_ports];
   logic [key_w-1:0]        w_best_key;
   logic                    w_any;
   logic                    w_found;
   logic [idx_width-1:0]    w_scan;
   logic [idx_width-1:0]    w_win_idx;

`ifdef WRARB_AGING_EN
   logic [age_width-1:0] r_age [num_of_ports];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         for (int i = 0; i < num_of_ports; i++) r_age[i] <= '0;
      end else begin
         for (int i = 0; i < num_of_ports; i++) begin
            if (!bus.req[i] || r_grant[i])
               r_age[i] <= '0;
            else if (r_age[i] != '1)
               r_age[i] <= r_age[i] + 1'b1;
         end
      end
   end

   always_comb begin
      for (int i = 0; i < num_of_ports; i++) w_urgent[i] = &r_age[i];
   end
`else
   assign w_urgent = '0;
`endif

   // Urgent bit on top of the priority lets a saturated age outrank any priority.
   always_comb begin
      for (int i = 0; i < num_of_ports; i++)
         w_key[i] = {w_urgent[i], bus.prio_flat[i*sg_priority_width +: sg_priority_width]};
   end

   always_comb begin
      w_any      = 1'b0;
      w_best_key = '0;
      for (int i = 0; i < num_of_ports; i++) begin
         if (bus.req[i] && (!w_any || w_key[i] > w_best_key)) begin
            w_best_key = w_key[i];
            w_any      = 1'b1;
         end
      end
      w_found   = 1'b0;
      w_win_idx = r_rr_ptr;
      w_scan    = r_rr_ptr;
      for (int k = 0; k < num_of_ports; k++) begin
         w_scan = r_rr_ptr + idx_width'(k);
         if (!w_found && bus.req[w_scan] && w_key[w_scan] == w_best_key) begin
            w_win_idx = w_scan;
            w_found   = 1'b1;
         end
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      w_grant_nxt       = r_grant;
      w_grant_idx_nxt   = r_grant_idx;
      w_transfering_nxt = r_transfering;
      w_beat_cnt_nxt    = r_beat_cnt;
      w_pkt_done_nxt    = 1'b0;
      w_timeout_err_nxt = 1'b0;
      w_rr_ptr_nxt      = r_rr_ptr;
      case (r_state)
         S_IDLE, S_GAP: begin
            if (!bus.busy && w_any) begin
               w_grant_nxt            = '0;
               w_grant_nxt[w_win_idx] = 1'b1;
               w_grant_idx_nxt        = w_win_idx;
               w_transfering_nxt      = 1'b1;
               w_beat_cnt_nxt         = '0;
               w_state_nxt            = S_XFER;
            end else begin
               w_grant_nxt       = '0;
               w_transfering_nxt = 1'b0;
               w_state_nxt       = S_IDLE;
            end
         end
         S_XFER: begin
            if (!bus.busy && r_beat_cnt != cnt_width'(max_beats))
               w_beat_cnt_nxt = r_beat_cnt + 1'b1;
            // eop outranks a coinciding timeout so the packet closes normally.
            if (bus.eop[r_grant_idx] ||
                (!bus.busy && r_beat_cnt == cnt_width'(max_beats - 1))) begin
               w_grant_nxt       = '0;
               w_transfering_nxt = 1'b0;
               w_rr_ptr_nxt      = r_grant_idx + 1'b1;
               w_state_nxt       = S_GAP;
               w_pkt_done_nxt    = bus.eop[r_grant_idx];
               w_timeout_err_nxt = !bus.eop[r_grant_idx];
            end
         end
         default: begin
            w_grant_nxt       = '0;
            w_transfering_nxt = 1'b0;
            w_state_nxt       = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= S_IDLE;
         r_grant       <= '0;
         r_grant_idx   <= '0;
         r_transfering <= 1'b0;
         r_beat_cnt    <= '0;
         r_pkt_done    <= 1'b0;
         r_timeout_err <= 1'b0;
         r_rr_ptr      <= '0;
      end else begin
         r_state       <= w_state_nxt;
         r_grant       <= w_grant_nxt;
         r_grant_idx   <= w_grant_idx_nxt;
         r_transfering <= w_transfering_nxt;
         r_beat_cnt    <= w_beat_cnt_nxt;
         r_pkt_done    <= w_pkt_done_nxt;
         r_timeout_err <= w_timeout_err_nxt;
         r_rr_ptr      <= w_rr_ptr_nxt;
      end
   end

   assign bus.grant       = r_grant;
   assign bus.grant_idx   = r_grant_idx;
   assign bus.transfering = r_transfering;
   assign bus.beat_cnt    = r_beat_cnt;
   assign bus.pkt_done    = r_pkt_done;
   assign bus.timeout_err = r_timeout_err;

endmodule

// File: tb/tb_wr_port_arbiter.sv
// tb/tb_wr_port_arbiter.sv - directed vector bench for wr_port_arbiter
module tb_wr_port_arbiter;

   typedef struct {
      logic [15:0] req;
      logic [47:0] prio;
      logic [15:0] eop;
      logic        busy;
      logic [15:0] grant;
      logic [3:0]  idx;
      logic        trans;
      logic [6:0]  cnt;
      logic        done;
      logic        to;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   wr_port_arbiter_if bus ();

   wr_port_arbiter dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   task automatic chk_all(input string nm, input logic [15:0] g, input logic [3:0] ix,
                          input logic tr, input logic [6:0] c, input logic d, input logic t);
      chk({nm, ".grant"},       64'(bus.grant),       64'(g));
      chk({nm, ".grant_idx"},   64'(bus.grant_idx),   64'(ix));
      chk({nm, ".transfering"}, 64'(bus.transfering), 64'(tr));
      chk({nm, ".beat_cnt"},    64'(bus.beat_cnt),    64'(c));
      chk({nm, ".pkt_done"},    64'(bus.pkt_done),    64'(d));
      chk({nm, ".timeout_err"}, 64'(bus.timeout_err), 64'(t));
   endtask

   function automatic vec_t mk(input logic [15:0] r, input logic [47:0] p, input logic [15:0] e,
                               input logic b, input logic [15:0] g, input logic [3:0] ix,
                               input logic tr, input logic [6:0] c, input logic d, input logic t);
      vec_t v;
      v.req = r; v.prio = p; v.eop = e; v.busy = b;
      v.grant = g; v.idx = ix; v.trans = tr; v.cnt = c; v.done = d; v.to = t;
      return v;
   endfunction

   vec_t vt [28];

   initial begin
      int nb;
      logic exp_to;
      vt[0]  = mk(16'h0005, 48'h82, 16'h0000, 0, 16'h0001, 0,  1, 0, 0, 0);
      vt[1]  = mk(16'h0005, 48'h82, 16'h0001, 0, 16'h0000, 0,  0, 1, 1, 0);
      vt[2]  = mk(16'h0005, 48'h82, 16'h0000, 0, 16'h0004, 2,  1, 0, 0, 0);
      vt[3]  = mk(16'h0000, 48'h82, 16'h0004, 0, 16'h0000, 2,  0, 1, 1, 0);
      vt[4]  = mk(16'h0000, 48'h82, 16'h0000, 0, 16'h0000, 2,  0, 1, 0, 0);
      vt[5]  = mk(16'h0003, 48'h29, 16'h0000, 0, 16'h0002, 1,  1, 0, 0, 0);
      vt[6]  = mk(16'h0003, 48'h29, 16'h0000, 0, 16'h0002, 1,  1, 1, 0, 0);
      vt[7]  = mk(16'h0003, 48'h29, 16'h0001, 0, 16'h0002, 1,  1, 2, 0, 0);
      vt[8]  = mk(16'h0003, 48'h29, 16'h0000, 1, 16'h0002, 1,  1, 2, 0, 0);
      vt[9]  = mk(16'h0003, 48'h29, 16'h0002, 1, 16'h0000, 1,  0, 2, 1, 0);
      vt[10] = mk(16'h0003, 48'h29, 16'h0000, 1, 16'h0000, 1,  0, 2, 0, 0);
      vt[11] = mk(16'h0003, 48'h29, 16'h0000, 0, 16'h0002, 1,  1, 0, 0, 0);
      vt[12] = mk(16'h0003, 48'h29, 16'h0002, 0, 16'h0000, 1,  0, 1, 1, 0);
      vt[13] = mk(16'h0001, 48'h29, 16'h0000, 0, 16'h0001, 0,  1, 0, 0, 0);
      vt[14] = mk(16'h0000, 48'h00, 16'h0001, 0, 16'h0000, 0,  0, 1, 1, 0);
      vt[15] = mk(16'h0008, 48'h00, 16'h0000, 0, 16'h0008, 3,  1, 0, 0, 0);
      vt[16] = mk(16'h0008, 48'h00, 16'h0020, 0, 16'h0008, 3,  1, 1, 0, 0);
      vt[17] = mk(16'h0008, 48'h00, 16'h0008, 0, 16'h0000, 3,  0, 2, 1, 0);
      vt[18] = mk(16'h0008, 48'h00, 16'h0000, 0, 16'h0008, 3,  1, 0, 0, 0);
      vt[19] = mk(16'h0000, 48'h00, 16'h0008, 0, 16'h0000, 3,  0, 1, 1, 0);
      vt[20] = mk(16'hFFFF, 48'h00, 16'h0000, 0, 16'h0010, 4,  1, 0, 0, 0);
      vt[21] = mk(16'h0000, 48'h00, 16'h0010, 0, 16'h0000, 4,  0, 1, 1, 0);
      vt[22] = mk(16'h0000, 48'h00, 16'h0000, 0, 16'h0000, 4,  0, 1, 0, 0);
      vt[23] = mk(16'h8001, 48'h00, 16'h0000, 0, 16'h8000, 15, 1, 0, 0, 0);
      vt[24] = mk(16'h0000, 48'h00, 16'h8000, 0, 16'h0000, 15, 0, 1, 1, 0);
      vt[25] = mk(16'h8001, 48'h00, 16'h0000, 0, 16'h0001, 0,  1, 0, 0, 0);
      vt[26] = mk(16'h0000, 48'h00, 16'h0001, 0, 16'h0000, 0,  0, 1, 1, 0);
      vt[27] = mk(16'h0000, 48'h00, 16'h0000, 0, 16'h0000, 0,  0, 1, 0, 0);

      bus.req = '0; bus.prio_flat = '0; bus.eop = '0; bus.busy = 1'b0;
      rst = 1'b1;
      step(); step();
      chk_all("reset", 16'h0, 4'h0, 1'b0, 7'd0, 1'b0, 1'b0);
      rst = 1'b0;

      for (int i = 0; i < 28; i++) begin
         bus.req = vt[i].req; bus.prio_flat = vt[i].prio;
         bus.eop = vt[i].eop; bus.busy = vt[i].busy;
         step();
         chk_all($sformatf("vec%0d", i), vt[i].grant, vt[i].idx, vt[i].trans,
                 vt[i].cnt, vt[i].done, vt[i].to);
      end

      // Timeout: port 3 with 10 stalled cycles inside a 64-beat packet.
      bus.req = 16'h0008; bus.prio_flat = '0; bus.eop = '0; bus.busy = 1'b0;
      step();
      chk_all("to_grant", 16'h0008, 4'd3, 1'b1, 7'd0, 1'b0, 1'b0);
      nb = 0;
      for (int j = 0; j < 74; j++) begin
         bus.busy = (j >= 20 && j < 30);
         step();
         if (!(j >= 20 && j < 30)) nb++;
         exp_to = (nb == 64);
         chk_all($sformatf("to_beat%0d", j), exp_to ? 16'h0 : 16'h0008, 4'd3,
                 !exp_to, 7'(nb), 1'b0, exp_to);
      end
      bus.req = '0; bus.busy = 1'b0;
      step();
      chk_all("to_idle", 16'h0, 4'd3, 1'b0, 7'd64, 1'b0, 1'b0);

      // Reset mid-packet; rr_ptr back to 0 is visible through the next tie-break.
      bus.req = 16'h0004;
      step();
      chk_all("rst_grant", 16'h0004, 4'd2, 1'b1, 7'd0, 1'b0, 1'b0);
      step();
      rst = 1'b1;
      step();
      chk_all("rst_mid", 16'h0, 4'd0, 1'b0, 7'd0, 1'b0, 1'b0);
      rst = 1'b0;
      bus.req = 16'hFFFF;
      step();
      chk_all("rst_rr", 16'h0001, 4'd0, 1'b1, 7'd0, 1'b0, 1'b0);
      bus.req = '0; bus.eop = 16'hFFFF;
      step();
      chk_all("rst_close", 16'h0, 4'd0, 1'b0, 7'd1, 1'b1, 1'b0);
      bus.eop = '0;
      step();

`ifdef WRARB_AGING_EN
      begin
         logic seen7;
         seen7 = 1'b0;
         rst = 1'b1; step(); rst = 1'b0;
         bus.prio_flat = 48'h3F;
         bus.req = 16'h0083;
         bus.eop = 16'hFFFF;
         for (int j = 0; j < 60; j++) begin
            step();
            if (bus.grant[7]) seen7 = 1'b1;
         end
         chk("aging_port7", 64'(seen7), 64'd1);
         bus.req = '0; bus.eop = '0;
         step();
      end
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
